riscv_fetch_unit: RTL and testbench

//  Decoupled instruction-fetch front end for the pipelined RISC-V core; replaces the bare PC register + IF/ID latch.

---
 rtl/riscv_fetch_unit_pkg.sv | 25 ++
 rtl/riscv_fetch_unit_if.sv | 40 ++++
 rtl/riscv_fetch_unit_fetch_fifo.sv | 69 ++++++
 rtl/riscv_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_fetch_unit_pkg.sv
// riscv_fetch_unit_pkg
//   Shared types and constants for the instruction-fetch front end:
//   FSM state encoding, RISC-V opcodes used by the static predecoder and
//   B/J immediate extraction helpers (sign-extended to 32 bits).
package riscv_fetch_unit_pkg;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } fetch_state_e;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // B-type: imm[12|10:5] = inst[31:25], imm[4:1|11] = inst[11:7]
    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // J-type: imm[20|10:1|11|19:12] = inst[31:12]
    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// riscv_fetch_unit_if
//   Groups the fetch unit's bus signals.
//   imem_req_*   : in-order instruction memory request channel
//   imem_rsp_*   : in-order instruction memory response channel
//   id_*         : queue head presented to decode (valid/ready)
//   redirect_*   : EX-stage redirect / flush
//   halt         : stop issuing new requests
//   master = fetch unit side, slave = memory/decode/EX side.
interface riscv_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;
    logic            id_pred_taken;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output id_valid, id_inst, id_pc, id_pc_plus4, id_pred_taken,
        input  id_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  id_valid, id_inst, id_pc, id_pc_plus4, id_pred_taken,
        output id_ready, redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/riscv_fetch_unit_fetch_fifo.sv
// fetch_fifo
//   Synchronous FIFO with flush, used for the instruction queue and the
//   PC tag FIFO of the fetch unit. DEPTH must be a power of 2.
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   flush_i  in   empty the FIFO (wins over push/pop in the same cycle)
//   push_i   in   write din_i (caller guarantees not full)
//   din_i    in   WIDTH data
//   pop_i    in   drop the head entry (ignored when empty)
//   head_o   out  head entry, 0 when empty; changes only on pop,
//                 push-to-empty or flush
//   count_o  out  occupancy, 0..DEPTH
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_pop;

    always_comb begin
        do_pop = pop_i && (cnt_q != '0);
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + AW'(1);
            if (do_pop) rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;
    end

    assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
//   Decoupled instruction-fetch front end. Generates PCs, issues in-order
//   requests to a variable-latency instruction memory and buffers returned
//   instructions in a DEPTH-entry queue presented to decode.
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-low reset (0 = reset)
//   bus   riscv_fetch_unit_if.master: imem request/response, decode
//         handshake {id_inst, id_pc, id_pc_plus4, id_pred_taken},
//         redirect_valid/redirect_pc, halt.
//   Optional feature: define FETCH_STATIC_PRED_EN to predecode responses
//   and redirect fetch on JAL / backward B-type (predicted taken).
module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    riscv_fetch_unit_if.master  bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned QW = 32 + 2 * XLEN + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   q_count, tag_count;
    logic [QW-1:0]   q_head, q_din;
    logic [XLEN-1:0] tag_head;
    logic            issue, rsp_live, q_pop, tag_pop, pred_taken;

    // Credit rule: queued + in-flight never exceeds DEPTH, so a response
    // always finds room in the queue.
    assign bus.imem_req_valid = rst && (state_q == S_RUN) && !bus.redirect_valid
                                && ((q_count + out_q) < CW'(DEPTH));
    assign bus.imem_req_addr  = pc_q;

    assign issue    = bus.imem_req_valid && bus.imem_req_ready;
    // A response in a redirect cycle belongs to the old stream and is dropped.
    assign rsp_live = bus.imem_rsp_valid && !bus.redirect_valid && (drop_q == '0);
    assign tag_pop  = rsp_live && (tag_count != '0);
    assign q_pop    = bus.id_valid && bus.id_ready;

`ifdef FETCH_STATIC_PRED_EN
    logic [6:0]      rsp_opcode;
    logic [31:0]     rsp_imm;
    logic [XLEN-1:0] pred_target;

    always_comb begin
        rsp_opcode  = bus.imem_rsp_data[6:0];
        rsp_imm     = (rsp_opcode == OPCODE_JAL) ? j_imm(bus.imem_rsp_data)
                                                 : b_imm(bus.imem_rsp_data);
        pred_taken  = rsp_live && ((rsp_opcode == OPCODE_JAL) ||
                                   ((rsp_opcode == OPCODE_BRANCH) && bus.imem_rsp_data[31]));
        pred_target = tag_head + XLEN'($signed(rsp_imm));
    end
`else
    assign pred_taken = 1'b0;
`endif

    assign q_din = {pred_taken, bus.imem_rsp_data, tag_head, tag_head + XLEN'(4)};

    assign bus.id_valid = (q_count != '0);
    assign {bus.id_pred_taken, bus.id_inst, bus.id_pc, bus.id_pc_plus4} = q_head;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        out_d   = out_q + CW'(issue) - CW'(bus.imem_rsp_valid);

        if (issue) pc_d = pc_q + XLEN'(4);
        if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        if ((state_q == S_RUN) && bus.halt) state_d = S_HALT;

`ifdef FETCH_STATIC_PRED_EN
        // Everything still in flight after this response (including a
        // request issued this same cycle) is on the wrong path.
        if (pred_taken) begin
            pc_d   = pred_target;
            drop_d = out_d;
        end
`endif

        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            drop_d  = out_d;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.redirect_valid),
        .push_i  (rsp_live),
        .din_i   (q_din),
        .pop_i   (q_pop),
        .head_o  (q_head),
        .count_o (q_count)
    );

    // Tag FIFO: PC of each live in-flight request, written at issue.
    // A predicted-taken response flushes it together with any same-cycle
    // issue, matching the drop count taken above.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.redirect_valid || pred_taken),
        .push_i  (issue),
        .din_i   (pc_q),
        .pop_i   (tag_pop),
        .head_o  (tag_head),
        .count_o (tag_count)
    );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit
//   Directed and randomized bench for riscv_fetch_unit. The reference model
//   is the architectural instruction stream: decode must see PCs in program
//   order from the last redirect target, each carrying mem_word(pc).
module tb_riscv_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    riscv_fetch_unit_if #(.XLEN(32)) bus ();

    riscv_fetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;
    int unsigned npop  = 0;
    int unsigned issues = 0;
    int unsigned last_due = 0;
    int unsigned lat_fix = 1;
    req_t        pend[$];
    int unsigned pop_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] last_issue = '1;
    logic [31:0] v_redirect_pc = 32'h0;
    bit          plant = 1'b0;
    bit          v_id_ready = 1'b0, idr_rand = 1'b0;
    bit          rdy_rand = 1'b0, rdy_fix = 1'b1, lat_rand = 1'b0;
    bit          v_redirect = 1'b0, v_halt = 1'b0;

    // Instruction memory content: ADDI-opcode words derived from the address;
    // a backward BEQ (imm = -16) is planted at 0x80 when 'plant' is set.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (plant && (a == 32'h80)) return 32'hFE0008E3;
        return {a[26:2] ^ 25'h0A5A5A5, 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, sample #1 later, model
    // memory and decode, then advance to the next negedge.
    task automatic step();
        req_t        r;
        bit          redir;
        bit          pexp;
        int unsigned lat;
        redir = v_redirect;
        bus.redirect_valid = redir;
        bus.redirect_pc    = v_redirect_pc;
        bus.halt           = v_halt;
        bus.imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        bus.id_ready       = redir ? 1'b0 : (idr_rand ? ($urandom_range(0, 9) < 7) : v_id_ready);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #1;
        if (redir) chk("req_blocked_on_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            lat    = lat_rand ? $urandom_range(1, 4) : lat_fix;
            r.addr = bus.imem_req_addr;
            r.due  = cyc + lat;
            if (r.due < last_due) r.due = last_due;
            last_due = r.due;
            pend.push_back(r);
            issues++;
            last_issue = r.addr;
        end
        chk("outstanding_bound", 32'(pend.size() <= 4), 32'd1);
        if (bus.id_valid && bus.id_ready) begin
            pexp = 1'b0;
`ifdef FETCH_STATIC_PRED_EN
            pexp = plant && (exp_pc == 32'h80);
`endif
            chk("id_pc", bus.id_pc, exp_pc);
            chk("id_inst", bus.id_inst, mem_word(exp_pc));
            chk("id_pc_plus4", bus.id_pc_plus4, exp_pc + 32'd4);
            chk("id_pred_taken", 32'(bus.id_pred_taken), 32'(pexp));
            pop_cyc.push_back(cyc);
            pop_pc.push_back(bus.id_pc);
            npop++;
            exp_pc = pexp ? 32'h70 : exp_pc + 32'd4;
        end
        if (redir) exp_pc = v_redirect_pc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        v_redirect    = 1'b1;
        v_redirect_pc = t;
        step();
        v_redirect    = 1'b0;
    endtask

    task automatic run_pops(input int unsigned n, input int unsigned bound, input string tag);
        int unsigned start;
        start = npop;
        for (int unsigned i = 0; i < bound && (npop - start) < n; i++) step();
        chk(tag, npop - start, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_list[8];

        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_id_pc", bus.id_pc, 32'h0);
        chk("rst_id_inst", bus.id_inst, 32'h0);
        chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'h0);
        chk("rst_id_pred", 32'(bus.id_pred_taken), 32'd0);

        // 1-cycle memory, decode always ready: back-to-back delivery
        rst        = 1'b1;
        exp_pc     = 32'h0;
        rdy_fix    = 1'b1;
        lat_fix    = 1;
        v_id_ready = 1'b1;
        pop_cyc.delete();
        pop_pc.delete();
        run_pops(4, 20, "t1_pops");
        if (pop_pc.size() >= 4) begin
            for (int unsigned i = 0; i < 4; i++) chk("t1_pc", pop_pc[i], 32'(i * 4));
            for (int unsigned i = 0; i < 3; i++)
                chk("t1_back_to_back", pop_cyc[i + 1] - pop_cyc[i], 32'd1);
        end

        // Decode stalled 10 cycles: exactly DEPTH requests, then none
        v_id_ready = 1'b0;
        redirect_to(32'h0);
        issues = 0;
        repeat (10) step();
        chk("t2_issue_count", issues, 32'd4);
        chk("t2_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
        v_id_ready = 1'b1;
        pop_pc.delete();
        run_pops(4, 20, "t2_drain");
        if (pop_pc.size() >= 4)
            for (int unsigned i = 0; i < 4; i++) chk("t2_pc", pop_pc[i], 32'(i * 4));

        // Latency 3, three outstanding, redirect drops stale responses
        v_id_ready = 1'b0;
        rdy_fix    = 1'b0;
        repeat (6) step();
        rdy_fix = 1'b1;
        lat_fix = 3;
        redirect_to(32'h300);
        for (int unsigned i = 0; i < 10 && pend.size() < 3; i++) step();
        chk("t3_three_outstanding", 32'(pend.size()), 32'd3);
        redirect_to(32'h100);
        chk("t3_queue_empty", 32'(bus.id_valid), 32'd0);
        v_id_ready = 1'b1;
        pop_pc.delete();
        run_pops(1, 30, "t3_first");
        if (pop_pc.size() >= 1) chk("t3_first_pc", pop_pc[0], 32'h100);

        // Halt at 0x20: issuing stops, queue drains, redirect resumes
        lat_fix    = 1;
        redirect_to(32'h0);
        last_issue = '1;
        for (int unsigned i = 0; i < 40 && last_issue != 32'h20; i++) step();
        chk("t4_reached_0x20", last_issue, 32'h20);
        v_halt = 1'b1;
        step();
        issues = 0;
        repeat (20) step();
        chk("t4_no_issue", issues, 32'd0);
        chk("t4_drained", 32'(bus.id_valid), 32'd0);
        chk("t4_all_delivered", exp_pc, last_issue + 32'd4);
        v_halt = 1'b0;
        redirect_to(32'h40);
        pop_pc.delete();
        run_pops(1, 20, "t4_resume");
        if (pop_pc.size() >= 1) chk("t4_resume_pc", pop_pc[0], 32'h40);

        // PC wrap-around
        redirect_to(32'hFFFF_FFF8);
        pop_pc.delete();
        run_pops(3, 20, "t5_pops");
        if (pop_pc.size() >= 3) begin
            chk("t5_pc0", pop_pc[0], 32'hFFFF_FFF8);
            chk("t5_pc1", pop_pc[1], 32'hFFFF_FFFC);
            chk("t5_pc2", pop_pc[2], 32'h0);
        end

`ifdef FETCH_STATIC_PRED_EN
        // Backward BEQ at 0x80 predicted taken to 0x70
        plant = 1'b1;
        redirect_to(32'h78);
        pop_pc.delete();
        run_pops(8, 60, "t6_pops");
        exp_list = '{32'h78, 32'h7C, 32'h80, 32'h70, 32'h74, 32'h78, 32'h7C, 32'h80};
        if (pop_pc.size() >= 8)
            for (int unsigned i = 0; i < 8; i++) chk("t6_pc", pop_pc[i], exp_list[i]);
        redirect_to(32'h2000);
        plant = 1'b0;
`else
        exp_list = '{default: 32'h0};
`endif

        // Randomized traffic: stalls, memory backpressure/latency, redirects, halts
        idr_rand = 1'b1;
        rdy_rand = 1'b1;
        lat_rand = 1'b1;
        for (int unsigned i = 0; i < 1500; i++) begin
            v_redirect = ($urandom_range(0, 99) < 3);
            if (v_redirect) v_redirect_pc = $urandom & 32'hFFFF_FFFC;
            v_halt = ($urandom_range(0, 99) < 2);
            step();
            v_redirect = 1'b0;
            v_halt     = 1'b0;
        end
        idr_rand   = 1'b0;
        rdy_rand   = 1'b0;
        lat_rand   = 1'b0;
        rdy_fix    = 1'b1;
        v_id_ready = 1'b1;
        redirect_to(32'h1000);
        pop_pc.delete();
        run_pops(4, 40, "t7_recover");
        if (pop_pc.size() >= 1) chk("t7_recover_pc", pop_pc[0], 32'h1000);

        // Reset asserted mid-transfer returns outputs to reset values at once
        rst = 1'b0;
        #1;
        chk("t8_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t8_rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("t8_rst_id_valid", 32'(bus.id_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
